multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter WAIT_W, default 4, width of the memory wait-state counter.
REQ-002 Parameter TIMEOUT, default 15, wait cycles before mem_timeout sets; SHALL be at most 2^WAIT_W-1.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 op  in  7  instruction opcode from the instruction register.
REQ-006 funct3  in  3  branch condition select.
REQ-007 Zero  in  1  ALU result equals zero.
REQ-008 ALUR31  in  1  ALU result bit 31.
REQ-009 mem_ready  in  1  memory completes the current access this cycle.
REQ-010 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  out  1 each  standard multicycle datapath enables.
REQ-011 ResultSrc  out  2  00 ALUOut, 01 ReadData, 10 ALUResult.
REQ-012 ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
REQ-013 ALUSrcB  out  2  00 rs2, 01 imm, 10 constant 4.
REQ-014 ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded.
REQ-015 ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-016 mem_timeout  out  1  sticky wait-timeout flag.
REQ-017 illegal  out  1  unrecognised opcode trap flag.
REQ-018 state  out  4  current FSM state, for debug.

Function
REQ-019 States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LINK=12, UPPER=13, TRAP=14; all outputs not listed for a state SHALL be 0.
REQ-020 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite=PCWrite=mem_ready; leave to DECODE only when mem_ready=1.
REQ-021 DECODE (ALUSrcA=01, ALUSrcB=01): op 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 or 0010111 -> UPPER.
REQ-022 MEMADR (ALUSrcA=10, ALUSrcB=01): go to MEMREAD for load, MEMWRITE for store.
REQ-023 MEMREAD: AdrSrc=1, ResultSrc=00; go to MEMWB when mem_ready=1.
REQ-024 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held for every wait cycle; go to FETCH when mem_ready=1.
REQ-025 MEMWB: ResultSrc=01, RegWrite=1; go to FETCH.
REQ-026 EXECR (ALUSrcA=10, ALUSrcB=00, ALUOp=10) and EXECI (ALUSrcA=10, ALUSrcB=01, ALUOp=10): go to ALUWB.
REQ-027 ALUWB: ResultSrc=00, RegWrite=1; go to FETCH.
REQ-028 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=taken; go to FETCH.
REQ-029 Branch taken by funct3: 000 Zero; 001 !Zero; 100 or 110 ALUR31; 101 or 111 !ALUR31; 010 or 011 never taken.
REQ-030 JAL: ResultSrc=00, PCWrite=1; go to LINK.
REQ-031 JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1; go to LINK.
REQ-032 LINK: ALUSrcA=01, ALUSrcB=10, ResultSrc=10, RegWrite=1; go to FETCH.
REQ-033 UPPER: ALUSrcA=11 for lui (op[5]=1) or 01 for auipc, ALUSrcB=01; go to ALUWB.
REQ-034 ImmSrc SHALL be decoded combinationally from op in every state: load, op-imm and jalr -> 000; store -> 001; branch -> 010; jal -> 011; lui and auipc -> 100; all other op -> 000.
REQ-035 Wait counter increments each cycle spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0, saturates at TIMEOUT, and clears on any state change.
REQ-036 mem_timeout SHALL set on the cycle the counter reaches TIMEOUT and stay set until reset; the FSM keeps waiting for mem_ready.
REQ-037 A mem_ready pulse outside FETCH, MEMREAD or MEMWRITE SHALL be ignored.

Reset
REQ-038 reset=1 at a clock edge: state=FETCH, wait counter=0, mem_timeout=0, illegal=0; reset overrides mem_ready and every transition.
REQ-039 Reset asserted mid-access (for example in MEMWRITE) aborts the access; MemWrite=0 from the first cycle after the reset edge.

Configuration
REQ-040 Macro ILLEGAL_TRAP_EN defined: an unrecognised op in DECODE -> TRAP; illegal=1 and all enables=0 in TRAP, held until reset.
REQ-041 Macro ILLEGAL_TRAP_EN undefined: an unrecognised op in DECODE -> FETCH (treated as a NOP); TRAP is unreachable and illegal is tied to 0.

Verification
REQ-042 lw with mem_ready low for 2 cycles in MEMREAD -> state sequence 0,1,2,3,3,3,4,0; RegWrite=1 only in MEMWB.
REQ-043 beq with Zero=1 -> PCWrite=1 in BRANCH; the same test with funct3=001 -> PCWrite=0.
REQ-044 sw with mem_ready held at 0 for 20 cycles -> MemWrite=1 throughout; mem_timeout rises after the 15th wait cycle and stays 1 after mem_ready arrives.
REQ-045 jalr -> states 11,12,0; PCWrite=1 in JALR; RegWrite=1 with ResultSrc=10 in LINK.
REQ-046 op=1111111 -> with ILLEGAL_TRAP_EN: state=14 and illegal=1 until reset; without it: state returns to 0 and illegal=0.
REQ-047 reset asserted in MEMWRITE -> next cycle state=0, MemWrite=0, mem_timeout=0.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for an RV32I-style multicycle datapath.
// Latency: selects and unconditional enables are registered with the state; the
//   mem_ready/branch qualifiers on PCWrite/IRWrite and the ImmSrc decode are combinational.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready=1; after TIMEOUT stalled
//   cycles a sticky mem_timeout is raised but the access is never abandoned.
// Ports: clk, reset (synchronous, active-high); op, funct3, Zero, ALUR31, mem_ready in;
//   PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
//   ImmSrc, mem_timeout, illegal, state (debug) out.
// Build option: define ILLEGAL_TRAP_EN to send unrecognised opcodes to a sticky TRAP
//   state; otherwise they retire as NOPs and illegal is tied low.
module multicycle_controller #(
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       Zero,
  input  logic       ALUR31,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       mem_timeout,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
    S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
    S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
    S_LINK = 4'd12, S_UPPER = 4'd13, S_TRAP = 4'd14
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              mem_timeout_q;
`ifdef ILLEGAL_TRAP_EN
  logic              illegal_q;
`endif

  // Moore outputs, registered from the next state so they line up with state_q.
  logic       adr_src_q, mem_write_q, reg_write_q, pc_uncond_q;
  logic       adr_src_d, mem_write_d, reg_write_d, pc_uncond_d;
  logic [1:0] result_src_q, alu_src_a_q, alu_src_b_q, alu_op_q;
  logic [1:0] result_src_d, alu_src_a_d, alu_src_b_d, alu_op_d;

  logic taken, waiting, fetch_done;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:         taken = Zero;
      3'b001:         taken = !Zero;
      3'b100, 3'b110: taken = ALUR31;
      3'b101, 3'b111: taken = !ALUR31;
      default:        taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I:              state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI, OP_AUIPC:  state_d = S_UPPER;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = S_TRAP;
`else
          default:           state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB, S_ALUWB, S_BRANCH, S_LINK: state_d = S_FETCH;
      S_EXECR, S_EXECI, S_UPPER:          state_d = S_ALUWB;
      S_JAL, S_JALR:                      state_d = S_LINK;
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    adr_src_d    = 1'b0;
    mem_write_d  = 1'b0;
    reg_write_d  = 1'b0;
    pc_uncond_d  = 1'b0;
    result_src_d = 2'b00;
    alu_src_a_d  = 2'b00;
    alu_src_b_d  = 2'b00;
    alu_op_d     = 2'b00;
    case (state_d)
      S_FETCH:    begin alu_src_b_d = 2'b10; result_src_d = 2'b10; end
      S_DECODE:   begin alu_src_a_d = 2'b01; alu_src_b_d = 2'b01; end
      S_MEMADR:   begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; end
      S_MEMREAD:  adr_src_d = 1'b1;
      S_MEMWRITE: begin adr_src_d = 1'b1; mem_write_d = 1'b1; end
      S_MEMWB:    begin result_src_d = 2'b01; reg_write_d = 1'b1; end
      S_EXECR:    begin alu_src_a_d = 2'b10; alu_op_d = 2'b10; end
      S_EXECI:    begin alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; alu_op_d = 2'b10; end
      S_ALUWB:    reg_write_d = 1'b1;
      S_BRANCH:   begin alu_src_a_d = 2'b10; alu_op_d = 2'b01; end
      S_JAL:      pc_uncond_d = 1'b1;
      S_JALR: begin
        alu_src_a_d = 2'b10; alu_src_b_d = 2'b01; result_src_d = 2'b10; pc_uncond_d = 1'b1;
      end
      S_LINK: begin
        alu_src_a_d = 2'b01; alu_src_b_d = 2'b10; result_src_d = 2'b10; reg_write_d = 1'b1;
      end
      // lui adds the immediate to zero, auipc to the PC of the instruction.
      S_UPPER:    begin alu_src_a_d = op[5] ? 2'b11 : 2'b01; alu_src_b_d = 2'b01; end
      default:    ;
    endcase
  end

  // Stall counter restarts whenever the FSM moves, so each access is timed on its own.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                    (state_q == S_MEMWRITE)) && !mem_ready;

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)                 wait_d = '0;
    else if (waiting && wait_q != WAIT_MAX) wait_d = wait_q + WAIT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      mem_timeout_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q     <= 1'b0;
`endif
      adr_src_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      pc_uncond_q   <= 1'b0;
      result_src_q  <= 2'b10;
      alu_src_a_q   <= 2'b00;
      alu_src_b_q   <= 2'b10;
      alu_op_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      if (wait_d == WAIT_MAX) mem_timeout_q <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
      illegal_q     <= (state_d == S_TRAP);
`endif
      adr_src_q     <= adr_src_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      pc_uncond_q   <= pc_uncond_d;
      result_src_q  <= result_src_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_op_q      <= alu_op_d;
    end
  end

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_STORE:         ImmSrc = 3'b001;
      OP_BRANCH:        ImmSrc = 3'b010;
      OP_JAL:           ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC: ImmSrc = 3'b100;
      default:          ImmSrc = 3'b000;
    endcase
  end

  assign fetch_done  = (state_q == S_FETCH) && mem_ready;
  assign IRWrite     = fetch_done;
  assign PCWrite     = pc_uncond_q || fetch_done || ((state_q == S_BRANCH) && taken);
  assign AdrSrc      = adr_src_q;
  assign MemWrite    = mem_write_q;
  assign RegWrite    = reg_write_q;
  assign ResultSrc   = result_src_q;
  assign ALUSrcA     = alu_src_a_q;
  assign ALUSrcB     = alu_src_b_q;
  assign ALUOp       = alu_op_q;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal     = illegal_q;
`else
  assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: self-checking bench for multicycle_controller.
// Latency: n/a (bench). Backpressure: drives mem_ready stalls of chosen lengths.
// Expected traces are built per instruction class from the architectural state sequence.
module tb_multicycle_controller;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       Zero, ALUR31, mem_ready;
  logic       PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, mem_timeout, illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state;

  multicycle_controller #(.WAIT_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .Zero(Zero), .ALUR31(ALUR31),
    .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .mem_timeout(mem_timeout),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  logic [21:0] outv;
  assign outv = {PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc, ALUSrcA,
                 ALUSrcB, ALUOp, ImmSrc, mem_timeout, illegal, state};

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                         RI = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111,
                         JR = 7'b1100111, LU = 7'b0110111, AU = 7'b0010111,
                         BAD = 7'b1111111;

  // Per-state constant outputs: {PCWrite, AdrSrc, MemWrite, RegWrite, ResultSrc, A, B, ALUOp}
  localparam logic [11:0] ST_TAB [15] = '{
    12'b0000_10_00_10_00,  // FETCH
    12'b0000_00_01_01_00,  // DECODE
    12'b0000_00_10_01_00,  // MEMADR
    12'b0100_00_00_00_00,  // MEMREAD
    12'b0001_01_00_00_00,  // MEMWB
    12'b0110_00_00_00_00,  // MEMWRITE
    12'b0000_00_10_00_10,  // EXECR
    12'b0000_00_10_01_10,  // EXECI
    12'b0001_00_00_00_00,  // ALUWB
    12'b0000_00_10_00_01,  // BRANCH
    12'b1000_00_00_00_00,  // JAL
    12'b1000_10_10_01_00,  // JALR
    12'b0001_10_01_10_00,  // LINK
    12'b0000_00_01_01_00,  // UPPER (A patched per op)
    12'b0000_00_00_00_00   // TRAP
  };

  typedef struct { int s; logic mr; } ent_t;
  ent_t q[$];

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic z; logic n;
    int exp_st; logic [2:0] exp_imm; logic exp_pcw;
  } vec_t;
  vec_t vecs[17];

  int   checks = 0;
  int   errors = 0;
  logic to_exp = 1'b0;
  int   run = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == SW) return 3'd1;
    if (o == BR) return 3'd2;
    if (o == JL) return 3'd3;
    if (o == LU || o == AU) return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [21:0] model(input int s, input logic mr);
    logic [11:0] t;
    logic [1:0]  a;
    logic        tk, pcw;
    t = ST_TAB[s];
    a = t[5:4];
    if (s == 13) a = op[5] ? 2'b11 : 2'b01;
    tk  = funct3[2] ? (ALUR31 ^ funct3[0]) : (!funct3[1] && (Zero ^ funct3[0]));
    pcw = t[11] | (s == 0 && mr) | (s == 9 && tk);
    return {pcw, t[10], (s == 0) && mr, t[9], t[8], t[7:6], a, t[3:2], t[1:0],
            imm_of(op), to_exp, s == 14, 4'(s)};
  endfunction

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    to_exp = 1'b0;
    run = 0;
  endtask

  task automatic push(input int s, input logic mr);
    ent_t e;
    e.s = s; e.mr = mr;
    q.push_back(e);
  endtask

  // Expected state trace for one instruction: fetch stalls, decode, class-specific tail.
  task automatic build(input logic [6:0] o, input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(0, 1'b0);
    push(0, 1'b1);
    push(1, 1'($urandom_range(0, 1)));
    case (o)
      LW: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push(3, 1'b0);
        push(3, 1'b1);
        push(4, 1'($urandom_range(0, 1)));
      end
      SW: begin
        push(2, 1'($urandom_range(0, 1)));
        for (int i = 0; i < mw; i++) push(5, 1'b0);
        push(5, 1'b1);
      end
      RR: begin push(6, 1'b1); push(8, 1'b0); end
      RI: begin push(7, 1'b0); push(8, 1'b1); end
      BR: push(9, 1'($urandom_range(0, 1)));
      JL: begin push(10, 1'b1); push(12, 1'b1); end
      JR: begin push(11, 1'b0); push(12, 1'b1); end
      LU, AU: begin push(13, 1'b1); push(8, 1'b0); end
      default: begin
`ifdef ILLEGAL_TRAP_EN
        push(14, 1'b1); push(14, 1'b0);
`endif
      end
    endcase
  endtask

  task automatic run_q();
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      #1;
      chk($sformatf("cyc_st%0d", q[i].s), 32'(outv), 32'(model(q[i].s, q[i].mr)));
      if ((q[i].s == 0 || q[i].s == 3 || q[i].s == 5) && !q[i].mr) begin
        run++;
        if (run == TIMEOUT) to_exp = 1'b1;
      end else begin
        run = 0;
      end
      tick();
    end
    q.delete();
  endtask

  logic [6:0] ops [10];

  initial begin
    vecs[0]  = '{LW, 3'd0, 1'b0, 1'b0, 2,  3'd0, 1'b0};
    vecs[1]  = '{SW, 3'd0, 1'b0, 1'b0, 2,  3'd1, 1'b0};
    vecs[2]  = '{RR, 3'd0, 1'b0, 1'b0, 6,  3'd0, 1'b0};
    vecs[3]  = '{RI, 3'd0, 1'b0, 1'b0, 7,  3'd0, 1'b0};
    vecs[4]  = '{JL, 3'd0, 1'b0, 1'b0, 10, 3'd3, 1'b0};
    vecs[5]  = '{JR, 3'd0, 1'b0, 1'b0, 11, 3'd0, 1'b0};
    vecs[6]  = '{LU, 3'd0, 1'b0, 1'b0, 13, 3'd4, 1'b0};
    vecs[7]  = '{AU, 3'd0, 1'b0, 1'b0, 13, 3'd4, 1'b0};
    vecs[8]  = '{BR, 3'b000, 1'b1, 1'b0, 9, 3'd2, 1'b1};
    vecs[9]  = '{BR, 3'b001, 1'b1, 1'b0, 9, 3'd2, 1'b0};
    vecs[10] = '{BR, 3'b100, 1'b0, 1'b1, 9, 3'd2, 1'b1};
    vecs[11] = '{BR, 3'b101, 1'b0, 1'b1, 9, 3'd2, 1'b0};
    vecs[12] = '{BR, 3'b110, 1'b1, 1'b0, 9, 3'd2, 1'b0};
    vecs[13] = '{BR, 3'b111, 1'b1, 1'b0, 9, 3'd2, 1'b1};
    vecs[14] = '{BR, 3'b010, 1'b1, 1'b1, 9, 3'd2, 1'b0};
    vecs[15] = '{BR, 3'b011, 1'b1, 1'b1, 9, 3'd2, 1'b0};
`ifdef ILLEGAL_TRAP_EN
    vecs[16] = '{BAD, 3'd0, 1'b0, 1'b0, 14, 3'd0, 1'b0};
`else
    vecs[16] = '{BAD, 3'd0, 1'b0, 1'b0, 0,  3'd0, 1'b0};
`endif
    ops = '{LW, SW, RR, RI, BR, JL, JR, LU, AU, BAD};

    reset = 1'b1; op = RR; funct3 = 3'd0; Zero = 1'b0; ALUR31 = 1'b0; mem_ready = 1'b0;
    do_reset();
    #1 chk("reset_vec", 32'(outv), 32'(model(0, 1'b0)));

    // Decode targets, ImmSrc and branch conditions from the vector table.
    foreach (vecs[i]) begin
      do_reset();
      op = vecs[i].op; funct3 = vecs[i].f3; Zero = vecs[i].z; ALUR31 = vecs[i].n;
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_decode", i), 32'(state), 32'd1);
      chk($sformatf("v%0d_imm", i), 32'(ImmSrc), 32'(vecs[i].exp_imm));
      tick();
      #1;
      chk($sformatf("v%0d_next", i), 32'(state), 32'(vecs[i].exp_st));
      if (vecs[i].exp_st == 9)
        chk($sformatf("v%0d_pcw", i), 32'(PCWrite), 32'(vecs[i].exp_pcw));
    end

    // lw with two MEMREAD stalls: 0,1,2,3,3,3,4 then back to 0.
    do_reset();
    op = LW;
    build(LW, 0, 2);
    run_q();
    #1 chk("lw_back_to_fetch", 32'(state), 32'd0);

    // jalr: 11, 12, 0.
    op = JR;
    build(JR, 1, 0);
    run_q();

    // sw stalled 20 cycles: timeout after the 15th wait, sticky past completion.
    op = SW;
    build(SW, 0, 20);
    run_q();
    #1 chk("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Reset in MEMWRITE aborts the store and clears the timeout flag.
    push(0, 1'b1); push(1, 1'b0); push(2, 1'b1); push(5, 1'b0); push(5, 1'b0);
    run_q();
    #1 chk("memwrite_before_rst", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    mem_ready = 1'b0;
    to_exp = 1'b0;
    run = 0;
    #1;
    chk("rst_mid_state", 32'(state), 32'd0);
    chk("rst_mid_memwrite", 32'(MemWrite), 32'd0);
    chk("rst_mid_timeout", 32'(mem_timeout), 32'd0);

    // Illegal opcode: trap held until reset, or NOP.
    op = BAD;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    #1;
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_state", 32'(state), 32'd14);
    chk("illegal_flag", 32'(illegal), 32'd1);
`else
    chk("illegal_state", 32'(state), 32'd0);
    chk("illegal_flag", 32'(illegal), 32'd0);
`endif
    do_reset();
    #1 chk("illegal_cleared", 32'(illegal), 32'd0);

    // Random instruction stream against the trace model.
    for (int n = 0; n < 80; n++) begin
      int k, mw;
`ifdef ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      mw = ($urandom_range(0, 7) == 0) ? 17 : $urandom_range(0, 3);
      op = ops[k];
      funct3 = 3'($urandom_range(0, 7));
      Zero = 1'($urandom_range(0, 1));
      ALUR31 = 1'($urandom_range(0, 1));
      build(ops[k], $urandom_range(0, 2), mw);
      run_q();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
